host_mem_loader: RTL and testbench

// - Host-side command engine upstream of the instruction and data block RAMs; drives their ext address/write/data ports.
// - Turns a 32-bit valid/ready word stream into burst writes and burst read-backs.
// - Read-back words return on a 32-bit valid/ready output stream.
// - Lets the host load shader code and data, and dump results, without per-word address handling.

---
 rtl/host_mem_loader.sv | 214 +++++++++++++++++++++
 tb/tb_host_mem_loader.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/host_mem_loader.sv
// Host command engine: turns a 32-bit word stream into burst writes/read-backs on the inst/data RAMs.
// Optional feature: define HOST_MEM_LOADER_CHECKSUM_EN to emit an XOR ack word after each WRITE.
module host_mem_loader #(
  parameter int unsigned ADDRESS_WIDTH = 16,
  parameter int unsigned WORD_WIDTH    = 32
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WORD_WIDTH-1:0]    in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WORD_WIDTH-1:0]    out_data,
  output logic                     busy,
  output logic                     error,
  output logic [ADDRESS_WIDTH-1:0] inst_address,
  output logic                     inst_write,
  output logic [WORD_WIDTH-1:0]    inst_in_data,
  input  logic [WORD_WIDTH-1:0]    inst_out_data,
  output logic [ADDRESS_WIDTH-1:0] data_address,
  output logic                     data_write,
  output logic [WORD_WIDTH-1:0]    data_in_data,
  input  logic [WORD_WIDTH-1:0]    data_out_data
);

  typedef enum logic [2:0] {
    StIdle,
    StAddr,
    StWrData,
    StRdIssue,
    StRdWait,
    StRdOut,
    StDone
  } state_e;

  localparam logic [1:0] OpWrite   = 2'b00;
  localparam logic [1:0] OpRead    = 2'b01;
  localparam logic [1:0] OpNop     = 2'b10;
  localparam logic [1:0] OpIllegal = 2'b11;

  state_e                   r_state;
  logic [1:0]               r_op;
  logic                     r_target;
  logic [15:0]              r_remaining;
  logic [ADDRESS_WIDTH-1:0] r_addr;
  logic                     r_in_ready;
  logic                     r_out_valid;
  logic [WORD_WIDTH-1:0]    r_out_data;
  logic                     r_error;
  logic [ADDRESS_WIDTH-1:0] r_inst_address;
  logic                     r_inst_write;
  logic [WORD_WIDTH-1:0]    r_inst_in_data;
  logic [ADDRESS_WIDTH-1:0] r_data_address;
  logic                     r_data_write;
  logic [WORD_WIDTH-1:0]    r_data_in_data;
`ifdef HOST_MEM_LOADER_CHECKSUM_EN
  logic [WORD_WIDTH-1:0]    r_csum;
`endif

  wire w_in_fire  = in_valid && r_in_ready;
  wire w_out_fire = r_out_valid && out_ready;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= StIdle;
      r_op           <= OpWrite;
      r_target       <= 1'b0;
      r_remaining    <= '0;
      r_addr         <= '0;
      r_in_ready     <= 1'b0;
      r_out_valid    <= 1'b0;
      r_out_data     <= '0;
      r_error        <= 1'b0;
      r_inst_address <= '0;
      r_inst_write   <= 1'b0;
      r_inst_in_data <= '0;
      r_data_address <= '0;
      r_data_write   <= 1'b0;
      r_data_in_data <= '0;
`ifdef HOST_MEM_LOADER_CHECKSUM_EN
      r_csum         <= '0;
`endif
    end else begin
      // Write strobes are single-cycle pulses unless re-armed below.
      r_inst_write <= 1'b0;
      r_data_write <= 1'b0;
      unique case (r_state)
        StIdle: begin
          r_in_ready <= 1'b1;
          if (w_in_fire) begin
            r_op        <= in_data[31:30];
            r_target    <= in_data[29];
            r_remaining <= in_data[15:0];
            unique case (in_data[31:30])
              OpWrite, OpRead: r_state <= StAddr;
              OpNop:           r_state <= StIdle;
              OpIllegal:       r_error <= 1'b1;
              default:         r_state <= StIdle;
            endcase
          end
        end
        StAddr: begin
          if (w_in_fire) begin
            r_addr <= in_data[ADDRESS_WIDTH-1:0];
`ifdef HOST_MEM_LOADER_CHECKSUM_EN
            r_csum <= '0;
`endif
            if (r_remaining == 16'd0) begin
              r_state    <= StDone;
              r_in_ready <= 1'b0;
`ifdef HOST_MEM_LOADER_CHECKSUM_EN
              if (r_op == OpWrite) begin
                r_out_valid <= 1'b1;
                r_out_data  <= '0;
              end
`endif
            end else if (r_op == OpWrite) begin
              r_state <= StWrData;
            end else begin
              r_state    <= StRdIssue;
              r_in_ready <= 1'b0;
              if (r_target) r_data_address <= in_data[ADDRESS_WIDTH-1:0];
              else          r_inst_address <= in_data[ADDRESS_WIDTH-1:0];
            end
          end
        end
        StWrData: begin
          if (w_in_fire) begin
            if (r_target) begin
              r_data_write   <= 1'b1;
              r_data_address <= r_addr;
              r_data_in_data <= in_data;
            end else begin
              r_inst_write   <= 1'b1;
              r_inst_address <= r_addr;
              r_inst_in_data <= in_data;
            end
            r_addr      <= r_addr + ADDRESS_WIDTH'(1);
            r_remaining <= r_remaining - 16'd1;
`ifdef HOST_MEM_LOADER_CHECKSUM_EN
            r_csum <= r_csum ^ in_data;
`endif
            if (r_remaining == 16'd1) begin
              r_state    <= StDone;
              r_in_ready <= 1'b0;
`ifdef HOST_MEM_LOADER_CHECKSUM_EN
              r_out_valid <= 1'b1;
              r_out_data  <= r_csum ^ in_data;
`endif
            end
          end
        end
        StRdIssue: begin
          r_state <= StRdWait;
        end
        StRdWait: begin
          // RAM output is valid one cycle after the address issued in StRdIssue.
          r_out_data  <= r_target ? data_out_data : inst_out_data;
          r_out_valid <= 1'b1;
          r_state     <= StRdOut;
        end
        StRdOut: begin
          if (w_out_fire) begin
            r_out_valid <= 1'b0;
            r_addr      <= r_addr + ADDRESS_WIDTH'(1);
            r_remaining <= r_remaining - 16'd1;
            if (r_remaining != 16'd1) begin
              r_state <= StRdIssue;
              if (r_target) r_data_address <= r_addr + ADDRESS_WIDTH'(1);
              else          r_inst_address <= r_addr + ADDRESS_WIDTH'(1);
            end else begin
              r_state <= StDone;
            end
          end
        end
        StDone: begin
`ifdef HOST_MEM_LOADER_CHECKSUM_EN
          if (r_out_valid) begin
            if (out_ready) begin
              r_out_valid <= 1'b0;
              r_state     <= StIdle;
              r_in_ready  <= 1'b1;
            end
          end else begin
            r_state    <= StIdle;
            r_in_ready <= 1'b1;
          end
`else
          r_state    <= StIdle;
          r_in_ready <= 1'b1;
`endif
        end
        default: begin
          r_state    <= StIdle;
          r_in_ready <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready     = r_in_ready;
  assign out_valid    = r_out_valid;
  assign out_data     = r_out_data;
  assign busy         = (r_state != StIdle);
  assign error        = r_error;
  assign inst_address = r_inst_address;
  assign inst_write   = r_inst_write;
  assign inst_in_data = r_inst_in_data;
  assign data_address = r_data_address;
  assign data_write   = r_data_write;
  assign data_in_data = r_data_in_data;

endmodule

// File: tb/tb_host_mem_loader.sv
// Directed self-checking bench for host_mem_loader with behavioural 1-cycle-latency RAM models.
module tb_host_mem_loader;

  logic        clock;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        busy;
  logic        error;
  logic [15:0] inst_address;
  logic        inst_write;
  logic [31:0] inst_in_data;
  logic [31:0] inst_out_data;
  logic [15:0] data_address;
  logic        data_write;
  logic [31:0] data_in_data;
  logic [31:0] data_out_data;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int out_xfers = 0;

  logic [31:0] inst_mem [0:65535];
  logic [31:0] data_mem [0:65535];

  logic [15:0] ilog_addr[$];
  logic [31:0] ilog_data[$];
  int          ilog_cyc[$];
  logic [15:0] dlog_addr[$];
  logic [31:0] dlog_data[$];

  host_mem_loader #(
    .ADDRESS_WIDTH(16),
    .WORD_WIDTH   (32)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .busy         (busy),
    .error        (error),
    .inst_address (inst_address),
    .inst_write   (inst_write),
    .inst_in_data (inst_in_data),
    .inst_out_data(inst_out_data),
    .data_address (data_address),
    .data_write   (data_write),
    .data_in_data (data_in_data),
    .data_out_data(data_out_data)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (inst_write) inst_mem[inst_address] <= inst_in_data;
    if (data_write) data_mem[data_address] <= data_in_data;
    inst_out_data <= inst_mem[inst_address];
    data_out_data <= data_mem[data_address];
    if (inst_write) begin
      ilog_addr.push_back(inst_address);
      ilog_data.push_back(inst_in_data);
      ilog_cyc.push_back(cyc);
    end
    if (data_write) begin
      dlog_addr.push_back(data_address);
      dlog_data.push_back(data_in_data);
    end
    if (out_valid && out_ready) out_xfers <= out_xfers + 1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic clear_logs();
    ilog_addr.delete(); ilog_data.delete(); ilog_cyc.delete();
    dlog_addr.delete(); dlog_data.delete();
  endtask

  // Present a word and return on the negedge after it was accepted (valid left high).
  task automatic send(input logic [31:0] w);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = w;
    while (!in_ready && n < 20) begin
      @(negedge clock);
      n++;
    end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL send_timeout word=%h in_ready=%b required 1", w, in_ready);
    end
    @(negedge clock);
  endtask

  task automatic wait_out(output logic [31:0] d, output logic ok);
    int n;
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clock);
      n++;
    end
    ok = out_valid;
    d  = out_data;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    repeat (2) @(negedge clock);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL reset_error got=%b exp=0", error); end
    checks++; if ({inst_write, data_write} !== 2'b00) begin
      errors++; $display("FAIL reset_writes got=%b exp=00", {inst_write, data_write});
    end
    checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
    checks++; if ({inst_address, data_address} !== 32'h0) begin
      errors++; $display("FAIL reset_addresses got=%h exp=0", {inst_address, data_address});
    end
    reset_n = 1'b1;
    @(negedge clock);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL idle_in_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_write_burst();
    clear_logs();
    send(32'h0000_0003); send(32'h0000_0010);
    send(32'hDEAD_BEEF); send(32'h1234_5678); send(32'hCAFE_F00D);
    in_valid = 1'b0;
    repeat (3) @(negedge clock);
    checks++;
    if (ilog_addr.size() != 3) begin
      errors++; $display("FAIL wr_count got=%0d exp=3", ilog_addr.size());
    end else begin
      if (ilog_addr[0] !== 16'h0010 || ilog_addr[1] !== 16'h0011 || ilog_addr[2] !== 16'h0012) begin
        errors++; $display("FAIL wr_addr got=%h,%h,%h exp=0010,0011,0012",
                           ilog_addr[0], ilog_addr[1], ilog_addr[2]);
      end
      checks++;
      if (ilog_data[0] !== 32'hDEAD_BEEF || ilog_data[1] !== 32'h1234_5678 ||
          ilog_data[2] !== 32'hCAFE_F00D) begin
        errors++; $display("FAIL wr_data got=%h,%h,%h exp=deadbeef,12345678,cafef00d",
                           ilog_data[0], ilog_data[1], ilog_data[2]);
      end
      checks++;
      if (ilog_cyc[1] != ilog_cyc[0] + 1 || ilog_cyc[2] != ilog_cyc[1] + 1) begin
        errors++; $display("FAIL wr_consecutive got cycles %0d,%0d,%0d exp consecutive",
                           ilog_cyc[0], ilog_cyc[1], ilog_cyc[2]);
      end
    end
    checks++; if (dlog_addr.size() != 0) begin
      errors++; $display("FAIL wr_data_ram_untouched got=%0d writes exp=0", dlog_addr.size());
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL wr_busy_end got=%b exp=0", busy); end
  endtask

  task automatic test_readback();
    logic [31:0] exp_w [3];
    logic [31:0] d;
    logic        ok;
    int          c1;
    exp_w[0] = 32'h1111_1111; exp_w[1] = 32'h2222_2222; exp_w[2] = 32'h3333_3333;
    send(32'h2000_0003); send(32'h0000_0010);
    for (int i = 0; i < 3; i++) send(exp_w[i]);
    in_valid = 1'b0;
    repeat (2) @(negedge clock);
    out_ready = 1'b0;
    send(32'h6000_0003); send(32'h0000_0010);
    in_valid = 1'b0;
    wait_out(d, ok);
    checks++; if (ok !== 1'b1 || d !== exp_w[0]) begin
      errors++; $display("FAIL rd_word0 got=%h valid=%b exp=%h", d, ok, exp_w[0]);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      checks++; if (out_valid !== 1'b1 || out_data !== exp_w[0]) begin
        errors++; $display("FAIL rd_hold cycle %0d got=%h valid=%b exp=%h", i, out_data, out_valid, exp_w[0]);
      end
    end
    out_ready = 1'b1;
    @(negedge clock);
    c1 = 0;
    for (int i = 1; i < 3; i++) begin
      wait_out(d, ok);
      checks++; if (ok !== 1'b1 || d !== exp_w[i]) begin
        errors++; $display("FAIL rd_word%0d got=%h valid=%b exp=%h", i, d, ok, exp_w[i]);
      end
      if (i == 1) c1 = cyc;
      else begin
        checks++; if (cyc - c1 != 3) begin
          errors++; $display("FAIL rd_throughput got=%0d cycles exp=3", cyc - c1);
        end
      end
      @(negedge clock);
    end
    repeat (2) @(negedge clock);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rd_busy_end got=%b exp=0", busy); end
  endtask

  task automatic test_wrap();
    logic [31:0] d;
    logic        ok;
    clear_logs();
    send(32'h2000_0002); send(32'h0000_FFFF);
    send(32'hAAAA_5555); send(32'h5555_AAAA);
    in_valid = 1'b0;
    repeat (3) @(negedge clock);
    checks++;
    if (dlog_addr.size() != 2 || dlog_addr[0] !== 16'hFFFF || dlog_addr[1] !== 16'h0000) begin
      errors++; $display("FAIL wrap_addr got n=%0d exp FFFF,0000", dlog_addr.size());
    end
    send(32'h6000_0002); send(32'h0000_FFFF);
    in_valid = 1'b0;
    wait_out(d, ok);
    checks++; if (ok !== 1'b1 || d !== 32'hAAAA_5555) begin
      errors++; $display("FAIL wrap_rd0 got=%h valid=%b exp=aaaa5555", d, ok);
    end
    @(negedge clock);
    wait_out(d, ok);
    checks++; if (ok !== 1'b1 || d !== 32'h5555_AAAA) begin
      errors++; $display("FAIL wrap_rd1 got=%h valid=%b exp=5555aaaa", d, ok);
    end
    repeat (3) @(negedge clock);
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL wrap_error got=%b exp=0", error); end
  endtask

  task automatic test_illegal_count0();
    int n;
    send(32'hC000_0000);
    in_valid = 1'b0;
    checks++; if (error !== 1'b1) begin errors++; $display("FAIL illegal_error got=%b exp=1", error); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL illegal_busy got=%b exp=0", busy); end
    clear_logs();
    send(32'h0000_0000); send(32'h0000_0005);
    in_valid = 1'b0;
    n = 0;
    while (busy && n < 2) begin
      @(negedge clock);
      n++;
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL count0_idle got busy=%b exp=0", busy); end
    repeat (2) @(negedge clock);
    checks++; if (ilog_addr.size() + dlog_addr.size() != 0) begin
      errors++; $display("FAIL count0_no_write got=%0d writes exp=0", ilog_addr.size() + dlog_addr.size());
    end
    checks++; if (error !== 1'b1) begin errors++; $display("FAIL error_sticky got=%b exp=1", error); end
  endtask

  task automatic test_reset_midburst();
    send(32'h0000_0004); send(32'h0000_0040);
    send(32'h0101_0101); send(32'h0202_0202);
    reset_n  = 1'b0;
    in_valid = 1'b0;
    #1;
    checks++; if (inst_write !== 1'b0) begin errors++; $display("FAIL rst_mid_write got=%b exp=0", inst_write); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_mid_in_ready got=%b exp=0", in_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got=%b exp=0", busy); end
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL rst_mid_error got=%b exp=0", error); end
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    clear_logs();
    send(32'h0000_0001); send(32'h0000_0050); send(32'h7777_8888);
    in_valid = 1'b0;
    repeat (3) @(negedge clock);
    checks++;
    if (ilog_addr.size() != 1 || ilog_addr[0] !== 16'h0050 || ilog_data[0] !== 32'h7777_8888) begin
      errors++; $display("FAIL rst_recover got n=%0d exp one write 7777_8888 at 0050", ilog_addr.size());
    end
  endtask

  task automatic test_checksum();
    out_ready = 1'b1;
    repeat (2) @(negedge clock);
    out_xfers = 0;
    send(32'h2000_0002); send(32'h0000_0080);
    send(32'h0F0F_0000); send(32'h00FF_00FF);
    in_valid = 1'b0;
`ifdef HOST_MEM_LOADER_CHECKSUM_EN
    checks++; if (out_valid !== 1'b1 || out_data !== 32'h0FF0_00FF) begin
      errors++; $display("FAIL csum_ack got=%h valid=%b exp=0ff000ff", out_data, out_valid);
    end
    repeat (5) @(negedge clock);
    checks++; if (out_xfers != 1) begin errors++; $display("FAIL csum_single got=%0d exp=1", out_xfers); end
`else
    repeat (6) @(negedge clock);
    checks++; if (out_xfers != 0) begin errors++; $display("FAIL no_ack got=%0d words exp=0", out_xfers); end
`endif
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL csum_busy_end got=%b exp=0", busy); end
  endtask

  initial begin
    test_reset();
    test_write_burst();
    test_readback();
    test_wrap();
    test_illegal_count0();
    test_reset_midburst();
    test_checksum();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
